pc_predict_unit: RTL



---
 rtl/pc_predict_unit_pkg.sv | 34 +++
 rtl/pc_predict_unit_if.sv | 37 +++
 rtl/pc_predict_unit_btb.sv | 58 +++++
 rtl/pc_predict_unit.sv | 92 +++++++++
 4 files changed

// File: rtl/pc_predict_unit_pkg.sv
// Shared types and helpers for the fetch-PC predictor: counter encodings and BTB geometry.
// No logic of its own; index/tag widths derive from XLEN and BTB depth.
package pc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam int DEF_XLEN        = 32;
  localparam int DEF_BTB_ENTRIES = 16;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Word-aligned fetch: the two low PC bits take part in neither index nor tag.
  function automatic int tag_w(input int xlen, input int entries);
    return xlen - 2 - $clog2(entries);
  endfunction

  localparam int DEF_IDX_W = idx_w(DEF_BTB_ENTRIES);
  localparam int DEF_TAG_W = tag_w(DEF_XLEN, DEF_BTB_ENTRIES);

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    if (taken) r = (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       r = (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch/execute bundle of the PC predictor; slave is the predictor, master is its environment.
// Pure wiring: no latency, no backpressure beyond the stall level.
interface pc_predict_unit_if #(
  parameter int XLEN = 32
) ();

  logic            stall;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pred_next;
  logic            pred_taken;
  logic            flush;

  logic            ex_valid;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_jalr;
  logic            ex_cond;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_pred_next;

  modport slave (
    input  stall,
    input  ex_valid, ex_branch, ex_jump, ex_jalr, ex_cond,
    input  ex_pc, ex_rs1_data, ex_imm, ex_pred_next,
    output pc, pred_next, pred_taken, flush
  );

  modport master (
    output stall,
    output ex_valid, ex_branch, ex_jump, ex_jalr, ex_cond,
    output ex_pc, ex_rs1_data, ex_imm, ex_pred_next,
    input  pc, pred_next, pred_taken, flush
  );

endinterface

// File: rtl/pc_predict_unit_btb.sv
// Direct-mapped BTB: two async read ports (fetch lookup, execute update) and one sync write port.
// Latency: reads 0 cycles, writes visible the cycle after; reset clears valids and blocks writes.
module btb_array
  import pc_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int ENTRIES = DEF_BTB_ENTRIES,
  parameter int IDX_W   = idx_w(ENTRIES),
  parameter int TAG_W   = tag_w(XLEN, ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output ctr_t             rd_ctr,
  output logic [XLEN-1:0]  rd_target,

  input  logic [IDX_W-1:0] ex_idx,
  input  logic [TAG_W-1:0] ex_tag,
  output logic             ex_hit,
  output ctr_t             ex_ctr,
  output logic [XLEN-1:0]  ex_target,

  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  ctr_t             wr_ctr
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr    = ctr_q[rd_idx];
  assign rd_target = tgt_q[rd_idx];

  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_ctr    = ctr_q[ex_idx];
  assign ex_target = tgt_q[ex_idx];

  // Only valid bits are reset; payload of an invalid entry is never consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      tgt_q[wr_idx]   <= wr_target;
      ctr_q[wr_idx]   <= wr_ctr;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC register with BTB next-PC prediction and execute-side mispredict redirect.
// Latency: prediction 0 cycles on pc, redirect lands next edge; stall holds pc unless flush.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int              XLEN        = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              BTB_ENTRIES = DEF_BTB_ENTRIES
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_predict_unit_if.slave bus
);

  localparam int              IDX_W = idx_w(BTB_ENTRIES);
  localparam int              TAG_W = tag_w(XLEN, BTB_ENTRIES);
  localparam logic [XLEN-1:0] FOUR  = XLEN'(4);

  logic [XLEN-1:0]  pc_q;

  logic             lk_hit;
  ctr_t             lk_ctr;
  logic [XLEN-1:0]  lk_target;
  logic             lk_taken;

  logic             ex_hit;
  ctr_t             ex_ctr;
  logic [XLEN-1:0]  ex_old_target;

  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  ex_target;
  logic [XLEN-1:0]  ex_seq;
  logic [XLEN-1:0]  actual;
  logic             taken;
  logic             mispredict;

  logic             wr_en;
  logic [XLEN-1:0]  wr_target;
  ctr_t             wr_ctr;

  // Fetch-side prediction.
  assign lk_taken       = lk_hit && lk_ctr[1];
  assign bus.pc         = pc_q;
  assign bus.pred_taken = lk_taken;
  assign bus.pred_next  = lk_taken ? lk_target : pc_q + FOUR;

  // Execute-side resolution; JALR clears bit 0 of the register-relative target.
  assign jalr_sum   = bus.ex_rs1_data + bus.ex_imm;
  assign ex_target  = bus.ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : bus.ex_pc + bus.ex_imm;
  assign ex_seq     = bus.ex_pc + FOUR;
  assign taken      = bus.ex_jump || (bus.ex_branch && bus.ex_cond);
  assign actual     = taken ? ex_target : ex_seq;
  assign mispredict = bus.ex_valid && (actual != bus.ex_pred_next);
  assign bus.flush  = mispredict;

  // Hits train the counter; misses allocate only when taken, evicting any alias.
  assign wr_en     = bus.ex_valid && (bus.ex_branch || bus.ex_jump) && (ex_hit || taken);
  assign wr_target = taken ? ex_target : ex_old_target;
  assign wr_ctr    = ex_hit ? ctr_next(ex_ctr, taken) : (bus.ex_jump ? ST : WT);

  btb_array #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (pc_q[2 +: IDX_W]),
    .rd_tag    (pc_q[XLEN-1 -: TAG_W]),
    .rd_hit    (lk_hit),
    .rd_ctr    (lk_ctr),
    .rd_target (lk_target),
    .ex_idx    (bus.ex_pc[2 +: IDX_W]),
    .ex_tag    (bus.ex_pc[XLEN-1 -: TAG_W]),
    .ex_hit    (ex_hit),
    .ex_ctr    (ex_ctr),
    .ex_target (ex_old_target),
    .wr_en     (wr_en),
    .wr_idx    (bus.ex_pc[2 +: IDX_W]),
    .wr_tag    (bus.ex_pc[XLEN-1 -: TAG_W]),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)          pc_q <= RESET_VEC;
    else if (mispredict) pc_q <= actual;
    else if (!bus.stall) pc_q <= bus.pred_next;
  end

endmodule
